// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one full-adder cell, LSB first
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_cnt;

  logic             w_bit;
  logic             w_carry;

  assign w_bit   = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_carry = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_res   <= '0;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_res   <= {w_bit, r_res[WIDTH-1:1]};
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_carry;
          // Final bit: publish the result directly so sum never shows partial shifts.
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_sum   <= {w_bit, r_res[WIDTH-1:1]};
            r_cout  <= w_carry;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - random and directed check of serial_adder at widths 8, 16 and 4
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        st [3];
  logic [31:0] av [3];
  logic [31:0] bv [3];
  logic        ci [3];

  logic        b8, b16, b4, d8, d16, d4, c8, c16, c4;
  logic [7:0]  s8;
  logic [15:0] s16;
  logic [3:0]  s4;

  logic        bz  [3];
  logic        dn  [3];
  logic [32:0] dsc [3];

  assign bz[0] = b8;  assign bz[1] = b16;  assign bz[2] = b4;
  assign dn[0] = d8;  assign dn[1] = d16;  assign dn[2] = d4;
  assign dsc[0] = {24'b0, c8, s8};
  assign dsc[1] = {16'b0, c16, s16};
  assign dsc[2] = {28'b0, c4, s4};

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(st[0]), .a(av[0][7:0]), .b(bv[0][7:0]), .cin(ci[0]),
    .busy(b8), .done(d8), .sum(s8), .cout(c8));
  serial_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(st[1]), .a(av[1][15:0]), .b(bv[1][15:0]), .cin(ci[1]),
    .busy(b16), .done(d16), .sum(s16), .cout(c16));
  serial_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(st[2]), .a(av[2][3:0]), .b(bv[2][3:0]), .cin(ci[2]),
    .busy(b4), .done(d4), .sum(s4), .cout(c4));

  int W [3] = '{8, 16, 4};

  // Model: an accepted op owns the unit for WIDTH busy cycles plus one done cycle.
  int          m_timer [3];
  logic [32:0] m_exp   [3];
  logic [32:0] m_pend  [3];
  int          m_acc   [3];
  int          m_abort [3];
  int          d_cnt   [3];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_timer[k] = 0; m_exp[k] = '0; m_pend[k] = '0;
      m_acc[k] = 0; m_abort[k] = 0; d_cnt[k] = 0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic [32:0] msk;
      msk = (33'd1 << W[k]) - 33'd1;
      if (rst) begin
        if (m_timer[k] > 1) m_abort[k]++;
        m_timer[k] = 0;
        m_exp[k]   = '0;
      end else if (m_timer[k] == 0) begin
        if (st[k]) begin
          m_pend[k]  = (33'(av[k]) & msk) + (33'(bv[k]) & msk) + 33'(ci[k]);
          m_timer[k] = W[k] + 1;
          m_acc[k]++;
        end
      end else begin
        m_timer[k]--;
        if (m_timer[k] == 1) m_exp[k] = m_pend[k];
      end
    end
  end

  task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("busy[w%0d]", W[k]), 33'(bz[k]), 33'(m_timer[k] > 1));
        check($sformatf("done[w%0d]", W[k]), 33'(dn[k]), 33'(m_timer[k] == 1));
        check($sformatf("sum[w%0d]", W[k]), dsc[k], m_exp[k]);
        if (dn[k] === 1'b1) d_cnt[k]++;
      end
    end
  end

  task automatic wait_done(input int k, output bit got, output int nbusy);
    got = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 100; i++) begin
      if (dn[k] === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (bz[k] === 1'b1) nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic op(input int k, input logic [31:0] a, input logic [31:0] b, input logic c,
                    input logic [32:0] exp_sc);
    bit got;
    int nb;
    for (int i = 0; i < 100 && m_timer[k] != 0; i++) @(negedge clk);
    st[k] = 1'b1; av[k] = a; bv[k] = b; ci[k] = c;
    @(negedge clk);
    st[k] = 1'b0;
    wait_done(k, got, nb);
    check($sformatf("op_done_seen[w%0d]", W[k]), 33'(got), 33'd1);
    check($sformatf("op_busy_cycles[w%0d]", W[k]), 33'(nb), 33'(W[k]));
    check($sformatf("op_literal[w%0d]", W[k]), dsc[k], exp_sc);
    check($sformatf("model_literal[w%0d]", W[k]), m_exp[k], exp_sc);
  endtask

  initial begin
    bit got;
    int nb;
    int cyc;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0; av[k] = '0; bv[k] = '0; ci[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("reset_busy", 33'(bz[k]), 33'd0);
      check("reset_done", 33'(dn[k]), 33'd0);
      check("reset_sum", dsc[k], 33'd0);
    end

    op(0, 32'h5A, 32'h3C, 1'b0, 33'h096);
    op(0, 32'hFF, 32'h01, 1'b0, 33'h100);
    op(0, 32'hFF, 32'hFF, 1'b1, 33'h1FF);
    op(2, 32'hF,  32'h0,  1'b1, 33'h010);
    op(1, 32'hFFFF, 32'h0001, 1'b0, 33'h10000);

    // start held high while operands churn every cycle
    st[0] = 1'b1; av[0] = 32'h11; bv[0] = 32'h22; ci[0] = 1'b0;
    @(negedge clk);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (dn[0] === 1'b1) begin got = 1'b1; break; end
      av[0] = $urandom; bv[0] = $urandom; ci[0] = 1'($urandom);
      @(negedge clk);
    end
    check("held_done_seen", 33'(got), 33'd1);
    check("held_literal", dsc[0], 33'h033);
    @(negedge clk);
    check("held_idle_gap", 33'(bz[0]), 33'd0);
    @(negedge clk);
    check("held_reaccept", 33'(bz[0]), 33'd1);
    st[0] = 1'b0;
    wait_done(0, got, nb);
    check("held_second_done", 33'(got), 33'd1);

    // reset in the 4th RUN cycle
    @(negedge clk);
    st[0] = 1'b1; av[0] = 32'h12; bv[0] = 32'h34; ci[0] = 1'b0;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_running", 33'(bz[0]), 33'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 33'(bz[0]), 33'd0);
    check("abort_done", 33'(dn[0]), 33'd0);
    check("abort_sum", dsc[0], 33'd0);
    op(0, 32'h12, 32'h34, 1'b0, 33'h046);

    cyc = 0;
    while ((d_cnt[0] < 1010 || d_cnt[1] < 1010) && cyc < 60000) begin
      for (int k = 0; k < 3; k++) begin
        st[k] = 1'($urandom); av[k] = $urandom; bv[k] = $urandom; ci[k] = 1'($urandom);
      end
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
      cyc++;
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) st[k] = 1'b0;
    check("random_budget_w8", 33'(d_cnt[0] >= 1000), 33'd1);
    check("random_budget_w16", 33'(d_cnt[1] >= 1000), 33'd1);
    repeat (40) @(negedge clk);
    for (int k = 0; k < 3; k++)
      check($sformatf("done_vs_accepts[w%0d]", W[k]), 33'(d_cnt[k]), 33'(m_acc[k] - m_abort[k]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
